// File: rtl/unidir_cb_cfg_pkg.sv
// Shared widths, field offsets and candidate indices for the unidirectional
// connection block and its configuration chain.
package ucb_cb_pkg;

    typedef enum logic [1:0] {CMT_NONE, CMT_DONE, CMT_ERR} commit_e;

    typedef enum logic [2:0] {CG_S1, CG_S0, CG_D1, CG_D0, CG_G, CG_X} cand_grp_e;

    function automatic int unsigned so_w(input int unsigned clbout0, input int unsigned clbout1);
        return $clog2(clbout0 + clbout1 + 1);
    endfunction

    function automatic int unsigned si_w(input int unsigned ws, input int unsigned wd,
                                         input int unsigned wg, input int unsigned clbx,
                                         input int unsigned clbout_opp);
        return $clog2(2 * (ws + wd) + wg + clbx * clbout_opp);
    endfunction

    function automatic int unsigned nbits_w(input int unsigned so, input int unsigned s0,
                                            input int unsigned s1, input int unsigned clbos,
                                            input int unsigned clbod, input int unsigned clbin0,
                                            input int unsigned clbin1);
        return 2 * so * (clbos + clbod) + s0 * clbin0 + s1 * clbin1;
    endfunction

    // Output fields come in pairs: side 0 drives the *1_out track, side 1 the *0_out track.
    function automatic int unsigned out_off(input int unsigned pair, input int unsigned side,
                                            input int unsigned so);
        return (2 * pair + side) * so;
    endfunction

    function automatic int unsigned in_off(input int unsigned base, input int unsigned idx,
                                           input int unsigned sw);
        return base + idx * sw;
    endfunction

    // Field index owning track t, or -1; a later field wins when several alias one track.
    function automatic int track_field(input int unsigned t, input int unsigned cnt,
                                       input int unsigned bias, input int unsigned modulus);
        int r;
        r = -1;
        for (int unsigned i = 0; i < cnt; i++)
            if ((i + bias * cnt) % modulus == t) r = int'(i);
        return r;
    endfunction

    function automatic int unsigned cand_base(input cand_grp_e g, input int unsigned ws,
                                              input int unsigned wd, input int unsigned wg);
        case (g)
            CG_S1:   return 0;
            CG_S0:   return ws;
            CG_D1:   return 2 * ws;
            CG_D0:   return 2 * ws + wd;
            CG_G:    return 2 * (ws + wd);
            default: return 2 * (ws + wd) + wg;
        endcase
    endfunction

endpackage

// File: rtl/unidir_cb_cfg_if.sv
// Serial configuration port, daisy-chained from tile to tile.
interface unidir_cb_cfg_if #(parameter int unsigned CFG_W = 1);
    logic             cfg_en;
    logic [CFG_W-1:0] cfg_in;
    logic [CFG_W-1:0] cfg_out;
    logic             cfg_commit;
    logic             cfg_done;
    logic             cfg_err;

    modport master (output cfg_en, cfg_in, cfg_commit, input cfg_out, cfg_done, cfg_err);
    modport slave  (input cfg_en, cfg_in, cfg_commit, output cfg_out, cfg_done, cfg_err);
endinterface

// File: rtl/unidir_cb_cfg_chain.sv
// Double-buffered configuration store: shadow shift chain, beat counter and
// atomic commit into the active bank.
module cb_cfg_chain
    import ucb_cb_pkg::*;
#(
    parameter int unsigned NBITS = 44,
    parameter int unsigned CFG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic [CFG_W-1:0] cfg_in,
    input  logic             cfg_commit,
    output logic [CFG_W-1:0] cfg_out,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [NBITS-1:0] active
);
    localparam int unsigned BEATS = (NBITS + CFG_W - 1) / CFG_W;
    localparam int unsigned SW    = BEATS * CFG_W;
    localparam int unsigned CW    = $clog2(BEATS + 1);

    logic [SW-1:0]    shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] active_q, active_d;
    commit_e          res_q, res_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            res_q    <= CMT_NONE;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            res_q    <= res_d;
        end
    end

    // A commit takes priority and swallows any shift requested in the same cycle.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        res_d    = CMT_NONE;
        if (cfg_commit) begin
            cnt_d = '0;
            if (cnt_q == CW'(BEATS)) begin
                active_d = shadow_q[NBITS-1:0];
                res_d    = CMT_DONE;
            end else begin
                res_d    = CMT_ERR;
            end
        end else if (cfg_en) begin
            shadow_d = SW'({cfg_in, shadow_q} >> CFG_W);
            if (cnt_q != CW'(BEATS)) cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        cfg_out  = shadow_q[CFG_W-1:0];
        cfg_done = (res_q == CMT_DONE);
        cfg_err  = (res_q == CMT_ERR);
        active   = active_q;
    end

endmodule

// File: rtl/unidir_cb_cfg.sv
// Unidirectional connection block between two CLB tiles; routing selects come
// from the committed bank of the on-block configuration chain.
module unidir_cb_cfg
    import ucb_cb_pkg::*;
#(
    parameter int unsigned WS         = 7,
    parameter int unsigned WD         = 6,
    parameter int unsigned WG         = 3,
    parameter int unsigned CLBIN0     = 2,
    parameter int unsigned CLBIN1     = 2,
    parameter int unsigned CLBOUT0    = 2,
    parameter int unsigned CLBOUT1    = 2,
    parameter int unsigned CARRY      = 1,
    parameter int unsigned CLBOS      = 2,
    parameter int unsigned CLBOS_BIAS = 1,
    parameter int unsigned CLBOD      = 2,
    parameter int unsigned CLBOD_BIAS = 1,
    parameter int unsigned CLBX       = 1,
    parameter int unsigned CFG_W      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WS-1:0]      single0_in,
    input  logic [WS-1:0]      single1_in,
    output logic [WS-1:0]      single0_out,
    output logic [WS-1:0]      single1_out,
    input  logic [WD-1:0]      double0_in,
    input  logic [WD-1:0]      double1_in,
    output logic [WD-1:0]      double0_out,
    output logic [WD-1:0]      double1_out,
    input  logic [WG-1:0]      global,
    input  logic [CLBOUT0-1:0] clb0_output,
    input  logic [CLBOUT1-1:0] clb1_output,
    input  logic [CARRY-1:0]   clb0_cout,
    input  logic [CARRY-1:0]   clb1_cout,
    output logic [CARRY-1:0]   clb0_cin,
    output logic [CARRY-1:0]   clb1_cin,
    output logic [CLBIN0-1:0]  clb0_input,
    output logic [CLBIN1-1:0]  clb1_input,
    unidir_cb_cfg_if.slave     cfg
);
    localparam int unsigned SO      = so_w(CLBOUT0, CLBOUT1);
    localparam int unsigned S0      = si_w(WS, WD, WG, CLBX, CLBOUT1);
    localparam int unsigned S1      = si_w(WS, WD, WG, CLBX, CLBOUT0);
    localparam int unsigned NBITS   = nbits_w(SO, S0, S1, CLBOS, CLBOD, CLBIN0, CLBIN1);
    localparam int unsigned OW      = 1 << SO;
    localparam int unsigned C0W     = 1 << S0;
    localparam int unsigned C1W     = 1 << S1;
    localparam int unsigned NB      = 2 * (WS + WD) + WG;
    localparam int unsigned IN0_OFF = 2 * SO * (CLBOS + CLBOD);
    localparam int unsigned IN1_OFF = IN0_OFF + S0 * CLBIN0;

    logic [NBITS-1:0]               active;
    logic [CLBOUT0+CLBOUT1-1:0]     clb_outs;
    logic [C0W-1:0]                 cand0;
    logic [C1W-1:0]                 cand1;

    cb_cfg_chain #(.NBITS(NBITS), .CFG_W(CFG_W)) u_chain (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg.cfg_en),
        .cfg_in     (cfg.cfg_in),
        .cfg_commit (cfg.cfg_commit),
        .cfg_out    (cfg.cfg_out),
        .cfg_done   (cfg.cfg_done),
        .cfg_err    (cfg.cfg_err),
        .active     (active)
    );

    assign clb_outs = {clb1_output, clb0_output};
    assign clb0_cin = clb1_cout;
    assign clb1_cin = clb0_cout;

    // Select 0 is pass-through, 1..N picks a CLB output, anything past that reads a zero pad.
    for (genvar t = 0; t < WS; t++) begin : g_single
        localparam int F = track_field(t, CLBOS, CLBOS_BIAS, WS);
        if (F >= 0) begin : g_mux
            logic [OW-1:0] ext1, ext0;
            assign ext1           = OW'({clb_outs, single0_in[t]});
            assign ext0           = OW'({clb_outs, single1_in[t]});
            assign single1_out[t] = ext1[active[out_off(F, 0, SO) +: SO]];
            assign single0_out[t] = ext0[active[out_off(F, 1, SO) +: SO]];
        end else begin : g_pass
            assign single1_out[t] = single0_in[t];
            assign single0_out[t] = single1_in[t];
        end
    end

    for (genvar t = 0; t < WD; t++) begin : g_double
        localparam int F = (t < WD / 2) ? track_field(t, CLBOD, CLBOD_BIAS, WD / 2) : -1;
        if (F >= 0) begin : g_mux
            logic [OW-1:0] ext1, ext0;
            assign ext1           = OW'({clb_outs, double0_in[t]});
            assign ext0           = OW'({clb_outs, double1_in[t]});
            assign double1_out[t] = ext1[active[out_off(CLBOS + F, 0, SO) +: SO]];
            assign double0_out[t] = ext0[active[out_off(CLBOS + F, 1, SO) +: SO]];
        end else begin : g_pass
            assign double1_out[t] = double0_in[t];
            assign double0_out[t] = double1_in[t];
        end
    end

    // Candidate tables are padded with zeros up to the full select range.
    always_comb begin
        cand0 = '0;
        cand1 = '0;
        cand0[cand_base(CG_S1, WS, WD, WG) +: WS] = single1_out;
        cand0[cand_base(CG_S0, WS, WD, WG) +: WS] = single0_out;
        cand0[cand_base(CG_D1, WS, WD, WG) +: WD] = double1_out;
        cand0[cand_base(CG_D0, WS, WD, WG) +: WD] = double0_out;
        cand0[cand_base(CG_G,  WS, WD, WG) +: WG] = global;
        cand1[NB-1:0] = cand0[NB-1:0];
        if (CLBX != 0) begin
            cand0[cand_base(CG_X, WS, WD, WG) +: CLBOUT1] = clb1_output;
            cand1[cand_base(CG_X, WS, WD, WG) +: CLBOUT0] = clb0_output;
        end
    end

    for (genvar k = 0; k < CLBIN0; k++) begin : g_in0
        assign clb0_input[k] = cand0[active[in_off(IN0_OFF, k, S0) +: S0]];
    end

    for (genvar k = 0; k < CLBIN1; k++) begin : g_in1
        assign clb1_input[k] = cand1[active[in_off(IN1_OFF, k, S1) +: S1]];
    end

endmodule

// File: tb/tb_unidir_cb_cfg.sv
// Directed bench for unidir_cb_cfg at default parameters (NBITS = BEATS = 44).
module tb_unidir_cb_cfg;

    logic       clk;
    logic       rst;
    logic [6:0] s0_in, s1_in, s0_out, s1_out;
    logic [5:0] d0_in, d1_in, d0_out, d1_out;
    logic [2:0] glb;
    logic [1:0] c0o, c1o, c0_in, c1_in;
    logic [0:0] c0cout, c1cout, c0cin, c1cin;

    int n_run  = 0;
    int n_fail = 0;

    logic [43:0] w1, w2, w3, wj;

    unidir_cb_cfg_if #(.CFG_W(1)) cfg_if ();

    unidir_cb_cfg dut (
        .clk         (clk),
        .rst         (rst),
        .single0_in  (s0_in),
        .single1_in  (s1_in),
        .single0_out (s0_out),
        .single1_out (s1_out),
        .double0_in  (d0_in),
        .double1_in  (d1_in),
        .double0_out (d0_out),
        .double1_out (d1_out),
        .global      (glb),
        .clb0_output (c0o),
        .clb1_output (c1o),
        .clb0_cout   (c0cout),
        .clb1_cout   (c1cout),
        .clb0_cin    (c0cin),
        .clb1_cin    (c1cin),
        .clb0_input  (c0_in),
        .clb1_input  (c1_in),
        .cfg         (cfg_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [43:0] w, input int unsigned n);
        for (int unsigned b = 0; b < n; b++) begin
            cfg_if.cfg_in = w[b];
            cfg_if.cfg_en = 1'b1;
            tick();
        end
        cfg_if.cfg_en = 1'b0;
    endtask

    task automatic commit();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        cfg_if.cfg_en     = 1'b0;
        cfg_if.cfg_in     = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        s0_in  = 7'b1011001;
        s1_in  = 7'b0110110;
        d0_in  = 6'b101101;
        d1_in  = 6'b010011;
        glb    = 3'b101;
        c0o    = 2'b10;
        c1o    = 2'b01;
        c0cout = 1'b1;
        c1cout = 1'b0;

        w1 = '0; w1[2:0] = 3'd3;
        w2 = '0;
        w2[5:3] = 3'd4;  w2[8:6] = 3'd7;  w2[17:15] = 3'd2;
        w2[28:24] = 5'd29; w2[33:29] = 5'd31; w2[38:34] = 5'd22; w2[43:39] = 5'd25;
        w3 = '0; w3[2:0] = 3'd2;
        wj = '1;

        #12;
        check("rst_s1_out", s1_out, 7'b1011001);
        check("rst_s0_out", s0_out, 7'b0110110);
        check("rst_d0_out", d0_out, 6'b010011);
        check("rst_d1_out", d1_out, 6'b101101);
        check("rst_clb0_in", c0_in, 2'b11);
        check("rst_clb1_in", c1_in, 2'b11);
        check("rst_clb1_cin", c1cin, 1'b1);
        check("rst_clb0_cin", c0cin, 1'b0);
        check("rst_cfg_out", cfg_if.cfg_out, 1'b0);
        check("rst_done", cfg_if.cfg_done, 1'b0);
        check("rst_err", cfg_if.cfg_err, 1'b0);
        rst = 1'b0;

        // Field 0 = 3: single1_out[2] takes clb1_output[0].
        shift_word(w1, 44);
        check("c1_cfg_out", cfg_if.cfg_out, 1'b1);
        commit();
        check("c1_done", cfg_if.cfg_done, 1'b1);
        check("c1_err", cfg_if.cfg_err, 1'b0);
        check("c1_s1_out", s1_out, 7'b1011101);
        check("c1_s0_out", s0_out, 7'b0110110);
        check("c1_d0_out", d0_out, 6'b010011);
        check("c1_clb0_in", c0_in, 2'b11);
        tick();
        check("c1_done_drop", cfg_if.cfg_done, 1'b0);

        // Mixed selects: out-of-range, CLB outputs, cross-CLB and chained candidates.
        shift_word(w2, 44);
        commit();
        check("c2_done", cfg_if.cfg_done, 1'b1);
        check("c2_s1_out", s1_out, 7'b1010001);
        check("c2_s0_out", s0_out, 7'b0110010);
        check("c2_d0_out", d0_out, 6'b010111);
        check("c2_d1_out", d1_out, 6'b101101);
        check("c2_clb0_in", c0_in, 2'b01);
        check("c2_clb1_in", c1_in, 2'b01);

        // Short load must be rejected without disturbing the active bank.
        shift_word(wj, 43);
        commit();
        check("short_err", cfg_if.cfg_err, 1'b1);
        check("short_done", cfg_if.cfg_done, 1'b0);
        check("short_s1_out", s1_out, 7'b1010001);
        check("short_clb0_in", c0_in, 2'b01);
        shift_word(wj, 1);
        commit();
        check("cnt_cleared_err", cfg_if.cfg_err, 1'b1);
        check("cnt_cleared_s0", s0_out, 7'b0110010);

        // Over-long load: counter saturates, last 44 beats are kept.
        shift_word(wj, 6);
        shift_word(w1, 44);
        commit();
        check("sat_done", cfg_if.cfg_done, 1'b1);
        check("sat_err", cfg_if.cfg_err, 1'b0);
        check("sat_s1_out", s1_out, 7'b1011101);
        check("sat_clb1_in", c1_in, 2'b11);

        // Asynchronous reset in the middle of a load.
        shift_word(w2, 20);
        #3 rst = 1'b1;
        #1;
        check("amid_s1_out", s1_out, 7'b1011001);
        check("amid_cfg_out", cfg_if.cfg_out, 1'b0);
        check("amid_clb0_in", c0_in, 2'b11);
        #1 rst = 1'b0;
        tick();
        commit();
        check("post_rst_err", cfg_if.cfg_err, 1'b1);

        // Commit and shift together at full count: commit wins, chain holds.
        shift_word(w3, 44);
        check("c3_cfg_out_pre", cfg_if.cfg_out, 1'b0);
        cfg_if.cfg_in     = 1'b1;
        cfg_if.cfg_en     = 1'b1;
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_en     = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        check("c3_done", cfg_if.cfg_done, 1'b1);
        check("c3_err", cfg_if.cfg_err, 1'b0);
        check("c3_cfg_out_hold", cfg_if.cfg_out, 1'b0);
        check("c3_s1_out", s1_out, 7'b1011101);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/unidir_cb_cfg.md
# unidir_cb_cfg

Second-generation unidirectional connection block with an on-block serial configuration chain. It routes single, double and global tracks plus CLB outputs between two neighbouring CLBs, as the first-generation block does, generalised to independent per-side input counts. Routing select bits are held in a double-buffered register (shadow shift chain plus active bank), so a fabric tile can be reprogrammed in place and switched atomically. Sits between two CLB tiles and daisy-chains its configuration port to the next tile.

## Interface
- WS, 7: single-track count per direction
- WD, 6: double-track count per direction (even)
- WG, 3: global lines
- CLBIN0 / CLBIN1, 2 / 2: muxed inputs driven into clb0 / clb1
- CLBOUT0 / CLBOUT1, 2 / 2: clb0 / clb1 outputs
- CARRY, 1: carry width
- CLBOS / CLBOS_BIAS, 2 / 1: number of muxed single tracks and their offset
- CLBOD / CLBOD_BIAS, 2 / 1: number of muxed double tracks and their offset
- CLBX, 1: 1 = the opposite CLB's outputs are input candidates
- CFG_W, 1: config bits per shift beat
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- single0_in/single1_in  in  WS; single0_out/single1_out  out  WS
- double0_in/double1_in  in  WD; double0_out/double1_out  out  WD
- global  in  WG
- clb0_output  in  CLBOUT0; clb1_output  in  CLBOUT1
- clb0_cout/clb1_cout  in  CARRY; clb0_cin/clb1_cin  out  CARRY
- clb0_input  out  CLBIN0; clb1_input  out  CLBIN1
- cfg_en  in  1  shift one beat
- cfg_in  in  CFG_W  serial data in; cfg_out  out  CFG_W  serial data out to next tile
- cfg_commit  in  1  copy shadow to active
- cfg_done  out  1  one-cycle pulse, commit accepted; cfg_err  out  1  one-cycle pulse, commit rejected

## Operation
- SO = clog2(CLBOUT0+CLBOUT1+1). S0 = clog2(2(WS+WD)+WG+CLBX·CLBOUT1). S1 = clog2(2(WS+WD)+WG+CLBX·CLBOUT0).
- NBITS = 2·SO·(CLBOS+CLBOD) + S0·CLBIN0 + S1·CLBIN1. BEATS = ceil(NBITS/CFG_W). The shadow is BEATS·CFG_W bits and the padding is ignored.
- Active bit layout, LSB first:
  - Output fields: for i in 0..CLBOS-1, the single1 field, then the single0 field, at track (i+CLBOS_BIAS·CLBOS)%WS.
  - Then the double fields in the same way, at track (i+CLBOD_BIAS·CLBOD)%(WD/2).
  - Then the clb0 input fields, then the clb1 input fields.
- Output mux select:
  - 0 = pass-through (single1_out[t]=single0_in[t], and the reverse).
  - k in 1..CLBOUT0+CLBOUT1 = {clb1_output, clb0_output}[k-1].
  - Larger values drive 0.
- Unmuxed tracks always pass through, including double tracks WD/2..WD-1.
- clb0 input candidates, index 0 upward: single1_out, single0_out, double1_out, double0_out, global, then clb1_output if CLBX=1. clb1 mirrors this with clb0_output.
- An input select beyond the candidate count drives 0.
- clb0_cin = clb1_cout and clb1_cin = clb0_cout, always.
- Shift: on cfg_en, the shadow shifts right by CFG_W and cfg_in enters at the top. cfg_out = shadow[CFG_W-1:0].
- Beat counter increments per shift and saturates at BEATS.
- Commit with counter == BEATS:
  - active ← shadow[NBITS-1:0]
  - cfg_done pulses
  - counter ← 0
- Commit with counter != BEATS: cfg_err pulses, counter ← 0, active is unchanged.
- cfg_commit and cfg_en in the same cycle: the commit is evaluated and the shift is ignored.

## Timing
- Routing is combinational from the active bank and the data inputs; zero latency.
- A new configuration is visible on outputs from the clk edge that samples cfg_commit.
- cfg_done/cfg_err are registered and high during the cycle after the commit edge.
- Reset, asynchronous, at any time including mid-shift:
  - shadow = 0, active = 0, counter = 0
  - cfg_done = cfg_err = 0, cfg_out = 0
  - all tracks pass through; every CLB input selects candidate 0 (single1_out[0]).
- Partial shifts survive idle cycles; only a commit or reset clears the counter.

## Structure
- Package ucb_cb_pkg holds:
  - clog2-based width functions (SO/S0/S1/NBITS)
  - the field-offset function
  - candidate-index constants
- One sub-module, cb_cfg_chain: shadow register, beat counter, commit/done/err logic; outputs active[NBITS-1:0].
- Top level: mux generate loops plus carry wiring.

## Test plan
Defaults: NBITS = 44, BEATS = 44.
- Reset, no config: single1_out == single0_in, double0_out == double1_in, clb0_input == 2'b{single1_out[0],single1_out[0]}, clb1_cin == clb0_cout.
- Shift 44 beats with field0=3, then commit: next edge cfg_done = 1, single1_out[2] == clb0_output[... wait index 2] i.e. {clb1_output,clb0_output}[2] == clb1_output[0]; all other tracks pass through.
- Select 7 in an output field: that track drives 0. Select 29 on clb0_input[0]: equals clb1_output[0]. Select 31: drives 0.
- Commit after 43 beats: cfg_err pulse, outputs unchanged, counter cleared. A subsequent full 44-beat load plus commit gives cfg_done.
- Assert rst after 20 beats: outputs return to pass-through immediately. A commit after 44 fresh beats succeeds.
- cfg_commit and cfg_en high together at count 44: commit succeeds, and cfg_out does not advance that cycle.
